// File: rtl/pipe_elastic_buf.sv
// pipe_elastic_buf: DEPTH-entry elastic valid/ready buffer with flush, bubble injection and occupancy
module pipe_elastic_buf #(
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] EMPTY_VAL = '0,
  parameter int                CNT_W     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              o_valid_q, i_ready_q;
  logic              insert, remove;
  assign insert  = i_valid & i_ready_q;
  assign remove  = o_valid_q & o_ready;
  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign count   = cnt_q;
  assign o_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : EMPTY_VAL;
  // next pointers and occupancy; flush collapses everything to the empty state
  always_comb begin
    wr_ptr_d = flush ? '0 : insert ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : remove ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    cnt_d    = flush ? '0 : cnt_q + CNT_W'(insert) - CNT_W'(remove);
  end
  // control state with handshake flags precomputed from the next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      o_valid_q <= cnt_d != '0;
      i_ready_q <= cnt_d < FULL;
    end
  end
  // payload storage; contents are irrelevant once cnt says the slot is empty
  always_ff @(posedge clk) begin
    if (insert) mem_q[wr_ptr_q] <= i_data;
  end
endmodule

// File: tb/tb_pipe_elastic_buf.sv
// tb_pipe_elastic_buf: directed checks of pipe_elastic_buf with DEPTH=3 and a NOP bubble value
module tb_pipe_elastic_buf;
  localparam int DW = 32;
  localparam int DEPTH = 3;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;
  logic          clk = 1'b0;
  logic          rst, flush, i_valid, i_ready, o_valid, o_ready;
  logic [DW-1:0] i_data, o_data;
  logic [1:0]    count;
  int            n_cmp = 0;
  int            n_err = 0;
  pipe_elastic_buf #(.DATA_W(DW), .DEPTH(DEPTH), .EMPTY_VAL(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    check({tag, ".o_valid"}, 32'(o_valid), 0);
    check({tag, ".i_ready"}, 32'(i_ready), 1);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".o_data"}, o_data, NOP);
  endtask
  task automatic push(input logic [DW-1:0] d);
    i_valid = 1'b1;
    i_data  = d;
    step();
    i_valid = 1'b0;
  endtask
  logic [DW-1:0] q[$];
  int sent, rcvd, cyc, mcnt;
  logic m_ins, m_rem;
  initial begin
    rst = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
    // 1: reset then idle
    step(); idle_chk("rst1");
    step(); idle_chk("rst2");
    rst = 1'b0;
    step(); idle_chk("idle1");
    step(); idle_chk("idle2");
    // 2: single pass
    o_ready = 1'b1;
    push(32'hA0);
    check("pass.o_valid", 32'(o_valid), 1);
    check("pass.o_data", o_data, 32'hA0);
    check("pass.count", 32'(count), 1);
    step(); idle_chk("pass_after");
    // 3: fill to full, reject a fourth, drain in order
    o_ready = 1'b0;
    push(32'h1); check("fill.count1", 32'(count), 1);
    push(32'h2); check("fill.count2", 32'(count), 2);
    push(32'h3); check("fill.count3", 32'(count), 3);
    check("fill.i_ready", 32'(i_ready), 0);
    push(32'h4);
    check("full.count", 32'(count), 3);
    check("full.head", o_data, 32'h1);
    o_ready = 1'b1;
    step();
    check("drain1.data", o_data, 32'h2);
    check("drain1.count", 32'(count), 2);
    check("drain1.i_ready", 32'(i_ready), 1);
    step();
    check("drain2.data", o_data, 32'h3);
    check("drain2.count", 32'(count), 1);
    step(); idle_chk("drained");
    // 4: wrap-around stream against a queue model, o_ready toggling
    sent = 0; rcvd = 0; cyc = 0; mcnt = 0;
    while (rcvd < 10 && cyc < 100) begin
      o_ready = (cyc % 2) == 0;
      i_valid = sent < 10;
      i_data  = 32'h100 + sent;
      check("wrap.o_valid", 32'(o_valid), 32'(q.size() != 0));
      check("wrap.o_data", o_data, q.size() != 0 ? q[0] : NOP);
      check("wrap.count", 32'(count), q.size());
      m_ins = i_valid && (mcnt < DEPTH);
      m_rem = o_ready && (mcnt != 0);
      step();
      if (m_rem) begin void'(q.pop_front()); rcvd++; mcnt--; end
      if (m_ins) begin q.push_back(32'h100 + sent); sent++; mcnt++; end
      cyc++;
    end
    i_valid = 1'b0;
    check("wrap.received", rcvd, 10);
    check("wrap.sent", sent, 10);
    step(); idle_chk("wrap_done");
    // 5: simultaneous insert and remove at count=2
    o_ready = 1'b0;
    push(32'h50);
    push(32'h51);
    check("sim.pre_count", 32'(count), 2);
    o_ready = 1'b1;
    push(32'h52);
    check("sim.count", 32'(count), 2);
    check("sim.head", o_data, 32'h51);
    step();
    check("sim.tail", o_data, 32'h52);
    check("sim.count_after", 32'(count), 1);
    step(); idle_chk("sim_done");
    // 6: flush when full, then flush with an acceptable insert
    o_ready = 1'b0;
    push(32'h61); push(32'h62); push(32'h63);
    check("flush.pre_count", 32'(count), 3);
    flush = 1'b1;
    push(32'hFF);
    flush = 1'b0;
    idle_chk("flush_full");
    step(); idle_chk("flush_after");
    push(32'h71);
    flush = 1'b1;
    push(32'hFF);
    flush = 1'b0;
    idle_chk("flush_part");
    push(32'h81);
    check("post_flush.data", o_data, 32'h81);
    check("post_flush.count", 32'(count), 1);
    // reset mid-operation drops the entry
    rst = 1'b1;
    push(32'h91);
    rst = 1'b0;
    idle_chk("rst_mid");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
